adc5g_gc2bin_pipe: RTL and testbench

- Multi-channel, pipelined Gray-code to binary converter for the ADC5G demux capture path; sits between the demux interface sample registers and the FIFO/packetiser.
- Gray decode is split across a parametrised number of register stages to meet timing at the demux clock.
- Runtime output format select: bypass, offset binary or two's complement.
- Per-channel over-range detection: a per-sample flag plus a saturating counter, with a clear strobe.

---
 rtl/adc5g_gc2bin_pipe_pkg.sv | 25 ++
 rtl/adc5g_gc2bin_pipe_if.sv | 26 ++
 rtl/adc5g_gc2bin_pipe_lane.sv | 103 ++++++++++
 rtl/adc5g_gc2bin_pipe.sv | 93 +++++++++
 tb/tb_adc5g_gc2bin_pipe.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc5g_gc2bin_pipe_pkg.sv
// Shared constants and stage-range helpers for the ADC5G Gray-to-binary capture pipe.
package adc5g_pkg;

  localparam int unsigned DATA_WIDTH_DFLT = 8;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_OFFSET = 2'b01;
  localparam logic [1:0] MODE_TWOS   = 2'b10;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // MSB of the bit slice resolved by stage s; negative means the stage has nothing left.
  function automatic int stage_hi(input int dw, input int ps, input int s);
    return dw - 1 - s * ceil_div(dw, ps);
  endfunction

  function automatic int stage_lo(input int dw, input int ps, input int s);
    int lo;
    lo = dw - (s + 1) * ceil_div(dw, ps);
    return (lo < 0) ? 0 : lo;
  endfunction

endpackage

// File: rtl/adc5g_gc2bin_pipe_if.sv
// Sample/control bundle between the demux capture registers and the converter.
interface adc5g_gc2bin_pipe_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic [1:0]                     mode;
  logic                           din_valid;
  logic [NUM_CH*DATA_WIDTH-1:0]   din;
  logic                           clr_cnt;
  logic                           dout_valid;
  logic [NUM_CH*DATA_WIDTH-1:0]   dout;
  logic [NUM_CH-1:0]              ovr_flag;
  logic [NUM_CH*CNT_WIDTH-1:0]    ovr_cnt;
  logic                           ovr_sticky;

  modport master (
    output mode, din_valid, din, clr_cnt,
    input  dout_valid, dout, ovr_flag, ovr_cnt, ovr_sticky
  );

  modport slave (
    input  mode, din_valid, din, clr_cnt,
    output dout_valid, dout, ovr_flag, ovr_cnt, ovr_sticky
  );
endinterface

// File: rtl/adc5g_gc2bin_pipe_lane.sv
// One channel: staged Gray decode, output format register and over-range flag/counter.
module adc5g_gc2bin_lane
  import adc5g_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DFLT,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] gc_i,
  input  logic                  vld_i,
  input  logic [1:0]            mode_i,
  input  logic                  clr_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  flag_o,
  output logic                  hit_o,
  output logic [CNT_WIDTH-1:0]  cnt_o
);

  for (genvar s = 0; s < int'(PIPE_STAGES); s++) begin : g_stage
    localparam int HI = stage_hi(int'(DATA_WIDTH), int'(PIPE_STAGES), s);
    localparam int LO = stage_lo(int'(DATA_WIDTH), int'(PIPE_STAGES), s);

    logic [DATA_WIDTH-1:0] g_in, b_in, b_d, g_q, b_q;
    logic                  p_in, par;

    if (s == 0) begin : g_first
      assign g_in = gc_i;
      assign b_in = '0;
      assign p_in = 1'b0;
    end else begin : g_next
      // Running parity is the lowest bit the previous stage resolved.
      localparam int PLO = stage_lo(int'(DATA_WIDTH), int'(PIPE_STAGES), s - 1);
      assign g_in = g_stage[s-1].g_q;
      assign b_in = g_stage[s-1].b_q;
      assign p_in = g_stage[s-1].b_q[PLO];
    end

    always_comb begin
      b_d = b_in;
      par = p_in;
      for (int unsigned j = 0; j < DATA_WIDTH; j++) begin
        if (int'(DATA_WIDTH - 1 - j) <= HI && int'(DATA_WIDTH - 1 - j) >= LO) begin
          par = par ^ g_in[DATA_WIDTH-1-j];
          b_d[DATA_WIDTH-1-j] = par;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        g_q <= '0;
        b_q <= '0;
      end else begin
        g_q <= g_in;
        b_q <= b_d;
      end
    end
  end

  logic [DATA_WIDTH-1:0] g_last, b_last, pre, dout_d, dout_q;
  logic                  flag_d, flag_q;
  logic [CNT_WIDTH-1:0]  cnt_d, cnt_q;

  assign g_last = g_stage[PIPE_STAGES-1].g_q;
  assign b_last = g_stage[PIPE_STAGES-1].b_q;

  always_comb begin
    pre    = (mode_i == MODE_BYPASS) ? g_last : b_last;
    dout_d = b_last;
    unique case (mode_i)
      MODE_BYPASS: dout_d = g_last;
      MODE_TWOS:   dout_d = {~b_last[DATA_WIDTH-1], b_last[DATA_WIDTH-2:0]};
      default:     dout_d = b_last;
    endcase
    flag_d = vld_i && ((pre == '0) || (pre == '1));
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (flag_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      flag_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      dout_q <= dout_d;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout_o = dout_q;
  assign flag_o = flag_q;
  assign hit_o  = flag_d;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/adc5g_gc2bin_pipe.sv
// Multi-channel pipelined Gray-to-binary converter: shared valid/mode pipe, lanes, sticky flag.
module adc5g_gc2bin_pipe
  import adc5g_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DFLT,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input logic               clk,
  input logic               rst,
  adc5g_gc2bin_pipe_if.slave bus
);

  logic [PIPE_STAGES-1:0] vld_d, vld_q;
  logic [1:0]             mode_d [PIPE_STAGES];
  logic [1:0]             mode_q [PIPE_STAGES];
  logic                   dout_valid_q;
  logic                   ev_d, ev_q, sticky_d, sticky_q;

  always_comb begin
    vld_d[0]  = bus.din_valid;
    mode_d[0] = bus.mode;
    for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
      vld_d[s]  = vld_q[s-1];
      mode_d[s] = mode_q[s-1];
    end
  end

  logic [DATA_WIDTH-1:0] lane_dout [NUM_CH];
  logic [CNT_WIDTH-1:0]  lane_cnt  [NUM_CH];
  logic [NUM_CH-1:0]     lane_flag, lane_hit;

  for (genvar c = 0; c < int'(NUM_CH); c++) begin : g_lane
    adc5g_gc2bin_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .PIPE_STAGES(PIPE_STAGES),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .gc_i  (bus.din[c*DATA_WIDTH +: DATA_WIDTH]),
      .vld_i (vld_q[PIPE_STAGES-1]),
      .mode_i(mode_q[PIPE_STAGES-1]),
      .clr_i (bus.clr_cnt),
      .dout_o(lane_dout[c]),
      .flag_o(lane_flag[c]),
      .hit_o (lane_hit[c]),
      .cnt_o (lane_cnt[c])
    );
  end

  // Sticky follows the flag one cycle later; a flag cleared on arrival must not set it.
  always_comb begin
    ev_d     = (|lane_hit) && !bus.clr_cnt;
    sticky_d = bus.clr_cnt ? 1'b0 : (sticky_q | ev_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q        <= '0;
      dout_valid_q <= 1'b0;
      ev_q         <= 1'b0;
      sticky_q     <= 1'b0;
      for (int unsigned s = 0; s < PIPE_STAGES; s++) mode_q[s] <= '0;
    end else begin
      vld_q        <= vld_d;
      dout_valid_q <= vld_q[PIPE_STAGES-1];
      ev_q         <= ev_d;
      sticky_q     <= sticky_d;
      for (int unsigned s = 0; s < PIPE_STAGES; s++) mode_q[s] <= mode_d[s];
    end
  end

  logic [NUM_CH*DATA_WIDTH-1:0] dout_w;
  logic [NUM_CH*CNT_WIDTH-1:0]  cnt_w;

  always_comb begin
    dout_w = '0;
    cnt_w  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      dout_w[c*DATA_WIDTH +: DATA_WIDTH] = lane_dout[c];
      cnt_w[c*CNT_WIDTH +: CNT_WIDTH]    = lane_cnt[c];
    end
  end

  assign bus.dout_valid = dout_valid_q;
  assign bus.dout       = dout_w;
  assign bus.ovr_flag   = lane_flag;
  assign bus.ovr_cnt    = cnt_w;
  assign bus.ovr_sticky = sticky_q;

endmodule

// File: tb/tb_adc5g_gc2bin_pipe.sv
// Directed bench: two converter instances (16-bit and 2-bit counters) driven in lockstep.
module tb_adc5g_gc2bin_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'b01;
  logic        din_valid = 1'b0;
  logic [31:0] din = '0;
  logic        clr_cnt = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc5g_gc2bin_pipe_if #(.DATA_WIDTH(8), .NUM_CH(4), .CNT_WIDTH(16)) bus16 ();
  adc5g_gc2bin_pipe_if #(.DATA_WIDTH(8), .NUM_CH(4), .CNT_WIDTH(2))  bus2 ();

  assign bus16.mode = mode;  assign bus16.din_valid = din_valid;
  assign bus16.din  = din;   assign bus16.clr_cnt   = clr_cnt;
  assign bus2.mode  = mode;  assign bus2.din_valid  = din_valid;
  assign bus2.din   = din;   assign bus2.clr_cnt    = clr_cnt;

  adc5g_gc2bin_pipe #(.DATA_WIDTH(8), .NUM_CH(4), .PIPE_STAGES(2), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus16)
  );
  adc5g_gc2bin_pipe #(.DATA_WIDTH(8), .NUM_CH(4), .PIPE_STAGES(2), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gray2bin(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (bus16.dout_valid !== 1'b0 || bus16.dout !== 32'h0 || bus16.ovr_flag !== 4'h0) begin
      errors++;
      $display("FAIL reset_out: valid=%b dout=%h flag=%b, want 0/0/0", bus16.dout_valid, bus16.dout, bus16.ovr_flag);
    end
    checks++;
    if (bus16.ovr_cnt !== 64'h0 || bus16.ovr_sticky !== 1'b0 || bus2.ovr_cnt !== 8'h0) begin
      errors++;
      $display("FAIL reset_cnt: cnt=%h sticky=%b cnt2=%h, want 0", bus16.ovr_cnt, bus16.ovr_sticky, bus2.ovr_cnt);
    end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_offset();
    logic [15:0] c3;
    mode = 2'b01; din = {8'h80, 8'hC0, 8'h03, 8'h01}; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    step();
    c3 = bus16.ovr_cnt[63:48];
    checks++;
    if (bus16.dout_valid !== 1'b1 || bus16.dout !== 32'hFF80_0201) begin
      errors++;
      $display("FAIL offset_dout: valid=%b dout=%h, want 1 ff800201", bus16.dout_valid, bus16.dout);
    end
    checks++;
    if (bus16.ovr_flag !== 4'b1000 || c3 !== 16'd1 || bus16.ovr_cnt[47:0] !== 48'h0) begin
      errors++;
      $display("FAIL offset_ovr: flag=%b cnt=%h, want 1000 and cnt3=1", bus16.ovr_flag, bus16.ovr_cnt);
    end
    step();
    checks++;
    if (bus16.dout_valid !== 1'b0 || bus16.ovr_flag !== 4'b0000 || bus16.ovr_sticky !== 1'b1) begin
      errors++;
      $display("FAIL offset_after: valid=%b flag=%b sticky=%b, want 0 0000 1", bus16.dout_valid, bus16.ovr_flag, bus16.ovr_sticky);
    end
  endtask

  task automatic test_twos();
    logic [15:0] c3;
    mode = 2'b10; din = {8'h80, 8'hC0, 8'h03, 8'h01}; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    step();
    c3 = bus16.ovr_cnt[63:48];
    checks++;
    if (bus16.dout_valid !== 1'b1 || bus16.dout !== 32'h7F00_8281) begin
      errors++;
      $display("FAIL twos_dout: valid=%b dout=%h, want 1 7f008281", bus16.dout_valid, bus16.dout);
    end
    checks++;
    if (bus16.ovr_flag !== 4'b1000 || c3 !== 16'd2) begin
      errors++;
      $display("FAIL twos_ovr: flag=%b cnt3=%0d, want 1000 and 2", bus16.ovr_flag, c3);
    end
  endtask

  task automatic test_exhaustive();
    logic [7:0] g, b;
    logic [3:0] fexp;
    mode = 2'b01;
    for (int k = 0; k < 258; k++) begin
      if (k < 256) begin
        g = 8'(k);
        din = {4{g}};
        din_valid = 1'b1;
      end else begin
        din_valid = 1'b0;
      end
      step();
      if (k >= 2) begin
        g = 8'(k - 2);
        b = gray2bin(g);
        fexp = (b == 8'h00 || b == 8'hFF) ? 4'hF : 4'h0;
        checks++;
        if (bus16.dout_valid !== 1'b1 || bus16.dout !== {4{b}}) begin
          errors++;
          $display("FAIL exh_dout g=%h: valid=%b dout=%h, want 1 %h", g, bus16.dout_valid, bus16.dout, {4{b}});
        end
        checks++;
        if (bus16.ovr_flag !== fexp) begin
          errors++;
          $display("FAIL exh_flag g=%h: flag=%b, want %b", g, bus16.ovr_flag, fexp);
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    din = {4{8'hC0}};
    mode = 2'b01; din_valid = 1'b1;
    step();
    mode = 2'b00;
    step();
    din_valid = 1'b0;
    step();
    checks++;
    if (bus16.dout_valid !== 1'b1 || bus16.dout !== {4{8'h80}}) begin
      errors++;
      $display("FAIL mode_sw_first: valid=%b dout=%h, want 1 80808080", bus16.dout_valid, bus16.dout);
    end
    step();
    checks++;
    if (bus16.dout_valid !== 1'b1 || bus16.dout !== {4{8'hC0}} || bus16.ovr_flag !== 4'h0) begin
      errors++;
      $display("FAIL mode_sw_second: valid=%b dout=%h flag=%b, want 1 c0c0c0c0 0000", bus16.dout_valid, bus16.dout, bus16.ovr_flag);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] c0;
    logic [1:0] exp_c [6];
    exp_c[0] = 2'd1; exp_c[1] = 2'd2; exp_c[2] = 2'd3;
    exp_c[3] = 2'd3; exp_c[4] = 2'd3; exp_c[5] = 2'd0;
    mode = 2'b01; din_valid = 1'b0; clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    checks++;
    if (bus2.ovr_cnt !== 8'h00 || bus2.ovr_sticky !== 1'b0) begin
      errors++;
      $display("FAIL sat_preclear: cnt=%h sticky=%b, want 00 0", bus2.ovr_cnt, bus2.ovr_sticky);
    end
    din = {8'h01, 8'h01, 8'h01, 8'h00};
    for (int k = 0; k < 9; k++) begin
      din_valid = (k < 6);
      clr_cnt   = (k == 7);
      step();
      c0 = bus2.ovr_cnt[1:0];
      if (k >= 2 && k <= 7) begin
        checks++;
        if (c0 !== exp_c[k-2]) begin
          errors++;
          $display("FAIL sat_cnt word%0d: cnt0=%0d, want %0d", k - 2, c0, exp_c[k-2]);
        end
      end
      if (k == 4) begin
        checks++;
        if (bus2.ovr_sticky !== 1'b1) begin
          errors++;
          $display("FAIL sat_sticky_set: sticky=%b, want 1", bus2.ovr_sticky);
        end
      end
      if (k >= 7) begin
        checks++;
        if (bus2.ovr_sticky !== 1'b0 || c0 !== 2'd0) begin
          errors++;
          $display("FAIL sat_clear k=%0d: sticky=%b cnt0=%0d, want 0 0", k, bus2.ovr_sticky, c0);
        end
      end
    end
    clr_cnt = 1'b0;
  endtask

  task automatic test_reset_midstream();
    int n, first;
    mode = 2'b01; din = {4{8'hC0}}; din_valid = 1'b1;
    step();
    step();
    din_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (bus16.dout_valid !== 1'b0 || bus16.dout !== 32'h0) begin
      errors++;
      $display("FAIL rst_async: valid=%b dout=%h, want 0 0", bus16.dout_valid, bus16.dout);
    end
    step();
    step();
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus16.dout_valid !== 1'b0) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL rst_flush: %0d stale valid words, want 0", n);
    end
    din = {4{8'h03}}; din_valid = 1'b1;
    n = 0; first = -1;
    for (int c = 1; c <= 6; c++) begin
      step();
      din_valid = 1'b0;
      if (bus16.dout_valid === 1'b1) begin
        n++;
        if (first < 0) first = c;
        checks++;
        if (bus16.dout !== {4{8'h02}}) begin
          errors++;
          $display("FAIL rst_new_dout: dout=%h, want 02020202", bus16.dout);
        end
      end
    end
    checks++;
    if (n != 1 || first != 3) begin
      errors++;
      $display("FAIL rst_latency: count=%0d first=%0d, want 1 at 3", n, first);
    end
  endtask

  initial begin
    test_reset();
    test_offset();
    test_twos();
    test_exhaustive();
    test_mode_switch();
    test_saturate();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
